// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, then
// shifts one byte + odd parity out on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txStart,
    input  logic       ps2ckIn,
    input  logic       ps2dtIn,
    output logic       ps2ckOe,
    output logic       ps2dtOe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_SHIFT    = 3'd2,
        S_ACK      = 3'd3,
        S_WAITIDLE = 3'd4,
        S_DONE     = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    state_t         state_q;
    logic [7:0]     data_q;
    logic           parity_q;
    logic [3:0]     bit_idx_q;
    logic [IW-1:0]  inh_cnt_q;
    logic [TW-1:0]  tmo_q;
    logic           ck_oe_q;
    logic           dt_oe_q;
    logic           busy_q;
    logic           done_q;
    logic           error_q;

    logic           ck_meta_q;
    logic           ck_sync_q;
    logic           dt_meta_q;
    logic           dt_sync_q;
    logic           ck_filt_q;
    logic           ck_filt_d;
    logic [FW-1:0]  filt_cnt_q;
    logic [FW-1:0]  filt_cnt_d;
    logic           fall_q;
    logic           tmo_expired;

    // Filtered clock only follows the synchronized pin after FILTER_LEN equal samples.
    always_comb begin
        ck_filt_d  = ck_filt_q;
        filt_cnt_d = '0;
        if (ck_sync_q != ck_filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                ck_filt_d = ck_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            ck_meta_q  <= 1'b1;
            ck_sync_q  <= 1'b1;
            dt_meta_q  <= 1'b1;
            dt_sync_q  <= 1'b1;
            ck_filt_q  <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            ck_meta_q  <= ps2ckIn;
            ck_sync_q  <= ck_meta_q;
            dt_meta_q  <= ps2dtIn;
            dt_sync_q  <= dt_meta_q;
            ck_filt_q  <= ck_filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= ck_filt_q & ~ck_filt_d;
        end
    end

    // A fall in the same cycle always beats the timeout.
    assign tmo_expired = !fall_q && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            inh_cnt_q <= '0;
            tmo_q     <= '0;
            ck_oe_q   <= 1'b0;
            dt_oe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (state_q inside {S_SHIFT, S_ACK, S_WAITIDLE}) begin
                tmo_q <= fall_q ? '0 : tmo_q + TW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (txStart) begin
                        data_q    <= txData;
                        parity_q  <= ~^txData;
                        busy_q    <= 1'b1;
                        ck_oe_q   <= 1'b1;
                        dt_oe_q   <= (INHIBIT_CYCLES == 1);
                        inh_cnt_q <= '0;
                        state_q   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                        ck_oe_q   <= 1'b0;
                        bit_idx_q <= '0;
                        tmo_q     <= '0;
                        state_q   <= S_SHIFT;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + IW'(1);
                        // Start bit goes out in the last inhibit cycle.
                        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) begin
                            dt_oe_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (fall_q) begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                        if (bit_idx_q < 4'd8) begin
                            dt_oe_q <= ~data_q[bit_idx_q[2:0]];
                        end else if (bit_idx_q == 4'd8) begin
                            dt_oe_q <= ~parity_q;
                        end else begin
                            dt_oe_q <= 1'b0;
                            state_q <= S_ACK;
                        end
                    end else if (tmo_expired) begin
                        dt_oe_q <= 1'b0;
                        ck_oe_q <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_FAIL;
                    end
                end
                S_ACK: begin
                    if (fall_q && !dt_sync_q) begin
                        state_q <= S_WAITIDLE;
                    end else if (fall_q || tmo_expired) begin
                        dt_oe_q <= 1'b0;
                        ck_oe_q <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_FAIL;
                    end
                end
                S_WAITIDLE: begin
                    if (ck_filt_q && dt_sync_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (tmo_expired) begin
                        dt_oe_q <= 1'b0;
                        ck_oe_q <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_FAIL;
                    end
                end
                S_DONE, S_FAIL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ps2ckOe = ck_oe_q;
    assign ps2dtOe = dt_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device model,
// response scoreboard and frame scoreboard.
module tb_ps2_host_tx;

    localparam int INH   = 50;
    localparam int TMO   = 2000;
    localparam int FLT   = 8;
    localparam int H     = 40;
    localparam int LIMIT = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ck_in;
    logic       dt_in;
    logic       ck_oe;
    logic       dt_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] dbg_state;

    logic       dev_ck = 1'b0;
    logic       dev_dt = 1'b0;
    logic       glitch = 1'b0;
    logic       ck_line;
    logic       dt_line;

    int total = 0;
    int bad   = 0;

    logic [0:0]  exp_q[$];
    logic [10:0] frame_q[$];

    always #5 clk = ~clk;

    assign ck_line = ~(ck_oe | dev_ck);
    assign dt_line = ~(dt_oe | dev_dt);
    assign ck_in   = ck_line & ~glitch;
    assign dt_in   = dt_line;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .CLOCK  (clk),
        .reset  (rst),
        .txData (tx_data),
        .txStart(tx_start),
        .ps2ckIn(ck_in),
        .ps2dtIn(dt_in),
        .ps2ckOe(ck_oe),
        .ps2dtOe(dt_oe),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .state_o(dbg_state)
    );

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = (ones % 2 == 0);
        f[10]  = 1'b1;
        return f;
    endfunction

    task automatic issue(input logic [7:0] d, input bit exp_err, input bit with_frame);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        exp_q.push_back(exp_err);
        if (with_frame) frame_q.push_back(frame_of(d));
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic device_run(input int pulses, input bit ack, input bit glitch_en, input bit poke);
        logic [10:0] got;
        logic [10:0] exp_f;
        int w;
        got = '0;
        w = 0;
        while (!(ck_line && !dt_line) && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        if (w >= LIMIT) begin
            fail_now("request_seen");
            return;
        end
        repeat (H) @(negedge clk);
        for (int i = 0; i < pulses; i++) begin
            if (i < 11) got[i] = dt_line;
            if (poke && i == 5) begin
                tx_start = 1'b1;
                tx_data  = 8'($urandom);
                @(negedge clk);
                tx_start = 1'b0;
            end
            if (i == 10 && ack) dev_dt = 1'b1;
            dev_ck = 1'b1;
            repeat (H) @(negedge clk);
            dev_ck = 1'b0;
            if (glitch_en) begin
                repeat (H / 2) @(negedge clk);
                glitch = 1'b1;
                repeat (5) @(negedge clk);
                glitch = 1'b0;
                repeat (H - H / 2 - 5) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        dev_dt = 1'b0;
        if (pulses == 11) begin
            if (frame_q.size() == 0) begin
                fail_now("frame_unexpected");
            end else begin
                exp_f = frame_q.pop_front();
                check("frame_bits", int'(got), int'(exp_f));
            end
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (busy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) fail_now("transfer_end");
        repeat (3) @(negedge clk);
    endtask

    // Response monitor: every done/error pulse pops one expected outcome.
    initial begin
        logic [0:0] e;
        forever begin
            @(negedge clk);
            if (!rst && (done || error)) begin
                if (exp_q.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", int'({done, error}), int'({~e[0], e[0]}));
                    check("resp_busy", int'(busy), 0);
                    check("resp_oe", int'({ck_oe, dt_oe}), 0);
                end
            end
        end
    end

    // Inhibit length monitor.
    initial begin
        int len;
        len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                len = 0;
            end else if (ck_oe) begin
                len++;
            end else if (len != 0) begin
                check("inhibit_len", len, INH);
                len = 0;
            end
        end
    end

    initial begin
        #(700_000);
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        logic [7:0] d;
        bit ack;
        bit g;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ck_oe", int'(ck_oe), 0);
        check("rst_dt_oe", int'(dt_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // 0xF4 with ACK
        issue(8'hF4, 1'b0, 1'b1);
        check("busy_after_start", int'(busy), 1);
        device_run(11, 1'b1, 1'b0, 1'b0);
        wait_end();

        // 0x00 with ACK; txStart in the done cycle must be dropped
        issue(8'h00, 1'b0, 1'b1);
        device_run(11, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) fail_now("done_wait");
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_in_done", int'(busy), 0);

        // missing ACK
        issue(8'hA7, 1'b1, 1'b1);
        device_run(11, 1'b0, 1'b0, 1'b0);
        wait_end();

        // silent device: timeout measured from REQ entry, then a normal transfer
        issue(8'h3C, 1'b1, 1'b0);
        n = 0;
        while (ck_oe && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        m = 0;
        while (!error && m < TMO + 100) begin
            @(negedge clk);
            m++;
        end
        check("timeout_delay", m, TMO);
        repeat (3) @(negedge clk);
        issue(8'h96, 1'b0, 1'b1);
        device_run(11, 1'b1, 1'b0, 1'b0);
        wait_end();

        // txStart pulsed mid-shift is ignored
        issue(8'h5A, 1'b0, 1'b1);
        device_run(11, 1'b1, 1'b0, 1'b1);
        wait_end();

        // reset mid-shift releases both lines at once
        issue(8'h51, 1'b0, 1'b0);
        device_run(4, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("busy_mid_shift", int'(busy), 1);
        check("dt_oe_mid_shift", int'(dt_oe), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_oe", int'({ck_oe, dt_oe}), 0);
        check("rst_async_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        issue(8'hED, 1'b0, 1'b1);
        device_run(11, 1'b1, 1'b0, 1'b0);
        wait_end();

        // sub-filter glitches on the clock
        issue(8'hC3, 1'b0, 1'b1);
        device_run(11, 1'b1, 1'b1, 1'b0);
        wait_end();

        // random bytes, ACK and glitches
        repeat (8) begin
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            g   = ($urandom_range(0, 1) == 1);
            issue(d, !ack, 1'b1);
            device_run(11, ack, g, 1'b0);
            wait_end();
        end

        repeat (10) @(negedge clk);
        check("resp_left", exp_q.size(), 0);
        check("frame_left", frame_q.size(), 0);
        check("final_busy", int'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
